// File: rtl/pong_referee_if.sv
// Ball/paddle/score bundle between the pong referee and the stepper/display side.
// The referee uses the slave modport; the game logic around it uses master.
interface pong_referee_if #(
  parameter int x_coords_width = 10,
  parameter int y_coords_width = 10,
  parameter int score_width    = 4
);
  logic [x_coords_width-1:0] ball_x;
  logic [y_coords_width-1:0] ball_y;
  logic [y_coords_width-1:0] left_paddle_y;
  logic [y_coords_width-1:0] right_paddle_y;
  logic [x_coords_width-1:0] old_x;
  logic [y_coords_width-1:0] old_y;
  logic                      touching_paddle;
  logic                      touching_wall;
  logic [score_width-1:0]    left_score;
  logic [score_width-1:0]    right_score;
  logic [1:0]                state;
  logic                      game_over;

  modport master (
    output ball_x, ball_y, left_paddle_y, right_paddle_y,
    input  old_x, old_y, touching_paddle, touching_wall,
    input  left_score, right_score, state, game_over
  );

  modport slave (
    input  ball_x, ball_y, left_paddle_y, right_paddle_y,
    output old_x, old_y, touching_paddle, touching_wall,
    output left_score, right_score, state, game_over
  );
endinterface

// File: rtl/pong_referee.sv
// Pong game referee: bounce pulses, goals, scores and serve/play/point/game-over sequencing.
// Optional SERVE_TOWARD_LOSER_EN: re-aims the serve at the side that conceded the last point.
module pong_referee #(
  parameter int x_coords_width = 10,
  parameter int y_coords_width = 10,
  parameter int screen_w       = 640,
  parameter int screen_h       = 480,
  parameter int ball_size      = 8,
  parameter int paddle_w       = 8,
  parameter int paddle_h       = 64,
  parameter int left_paddle_x  = 16,
  parameter int right_paddle_x = 616,
  parameter int score_width    = 4,
  parameter int win_score      = 11,
  parameter int serve_delay    = 60,
  parameter int guard_cycles   = 3
) (
  input logic           clk,
  input logic           reset,
  pong_referee_if.slave bus
);
  // Two spare bits so position + size sums never wrap in the geometry checks.
  localparam int xe      = x_coords_width + 2;
  localparam int ye      = y_coords_width + 2;
  localparam int cnt_w   = $clog2(serve_delay + 1);
  localparam int guard_w = $clog2(guard_cycles + 2);

  localparam logic [x_coords_width-1:0] centre_x = x_coords_width'(screen_w / 2 - ball_size / 2);
  localparam logic [y_coords_width-1:0] centre_y = y_coords_width'(screen_h / 2 - ball_size / 2);
  localparam logic [xe-1:0] x_ball      = xe'(ball_size);
  localparam logic [xe-1:0] x_screen    = xe'(screen_w);
  localparam logic [xe-1:0] x_goal_left = xe'(screen_w - ball_size);
  localparam logic [xe-1:0] x_paddle_w  = xe'(paddle_w);
  localparam logic [ye-1:0] y_ball      = ye'(ball_size);
  localparam logic [ye-1:0] y_wall_low  = ye'(screen_h - ball_size);
  localparam logic [ye-1:0] y_paddle_h  = ye'(paddle_h);
  localparam logic [cnt_w-1:0]       serve_last = cnt_w'(serve_delay - 1);
  localparam logic [guard_w-1:0]     guard_load = guard_w'(guard_cycles);
  localparam logic [score_width-1:0] win        = score_width'(win_score);

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    PLAY      = 2'd1,
    POINT     = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  logic [xe-1:0] bx_e;
  logic [ye-1:0] by_e;
  logic [y_coords_width-1:0] paddle_top [2];
  logic [1:0] paddle_hits;
  logic paddle_any, wall_hit, goal_left, goal_right;

  assign bx_e          = {2'b00, bus.ball_x};
  assign by_e          = {2'b00, bus.ball_y};
  assign paddle_top[0] = bus.left_paddle_y;
  assign paddle_top[1] = bus.right_paddle_y;

  for (genvar gi = 0; gi < 2; gi++) begin : g_paddle
    localparam logic [xe-1:0] pad_x = xe'((gi == 0) ? left_paddle_x : right_paddle_x);
    logic [ye-1:0] pad_y;
    assign pad_y = {2'b00, paddle_top[gi]};
    assign paddle_hits[gi] = (bx_e < pad_x + x_paddle_w) && (bx_e + x_ball > pad_x) &&
                             (by_e + y_ball > pad_y) && (by_e < pad_y + y_paddle_h);
  end

  assign paddle_any = |paddle_hits;
  assign wall_hit   = (bus.ball_y == '0) || (by_e >= y_wall_low);
  // A ball stepped left past 0 wraps to a huge value, so >= screen_w is a right-side goal.
  assign goal_right = (bus.ball_x == '0) || (bx_e >= x_screen);
  assign goal_left  = (bx_e >= x_goal_left) && (bx_e < x_screen);

  state_t                    state_reg, state_next;
  logic [cnt_w-1:0]          serve_cnt_reg, serve_cnt_next;
  logic [score_width-1:0]    left_score_reg, left_score_next;
  logic [score_width-1:0]    right_score_reg, right_score_next;
  logic [score_width-1:0]    scorer_count;
  logic [x_coords_width-1:0] old_x_reg, old_x_next;
  logic [y_coords_width-1:0] old_y_reg, old_y_next;
  logic                      paddle_pulse_reg, paddle_pulse_next;
  logic                      wall_pulse_reg, wall_pulse_next;
  logic                      game_over_reg, game_over_next;
  logic [guard_w-1:0]        wall_guard_reg, wall_guard_next;
  logic [guard_w-1:0]        paddle_guard_reg, paddle_guard_next;
  logic                      x_dir_reg, x_dir_next;
  logic                      left_scored_reg, left_scored_next;
`ifdef SERVE_TOWARD_LOSER_EN
  logic                      after_point_reg, after_point_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= SERVE;
      serve_cnt_reg    <= '0;
      left_score_reg   <= '0;
      right_score_reg  <= '0;
      old_x_reg        <= centre_x;
      old_y_reg        <= centre_y;
      paddle_pulse_reg <= 1'b0;
      wall_pulse_reg   <= 1'b0;
      game_over_reg    <= 1'b0;
      wall_guard_reg   <= '0;
      paddle_guard_reg <= '0;
      x_dir_reg        <= 1'b0;
      left_scored_reg  <= 1'b0;
`ifdef SERVE_TOWARD_LOSER_EN
      after_point_reg  <= 1'b0;
`endif
    end else begin
      state_reg        <= state_next;
      serve_cnt_reg    <= serve_cnt_next;
      left_score_reg   <= left_score_next;
      right_score_reg  <= right_score_next;
      old_x_reg        <= old_x_next;
      old_y_reg        <= old_y_next;
      paddle_pulse_reg <= paddle_pulse_next;
      wall_pulse_reg   <= wall_pulse_next;
      game_over_reg    <= game_over_next;
      wall_guard_reg   <= wall_guard_next;
      paddle_guard_reg <= paddle_guard_next;
      x_dir_reg        <= x_dir_next;
      left_scored_reg  <= left_scored_next;
`ifdef SERVE_TOWARD_LOSER_EN
      after_point_reg  <= after_point_next;
`endif
    end
  end

  assign scorer_count = (left_scored_reg ? left_score_reg : right_score_reg) + score_width'(1);

  always_comb begin
    state_next        = state_reg;
    serve_cnt_next    = serve_cnt_reg;
    left_score_next   = left_score_reg;
    right_score_next  = right_score_reg;
    old_x_next        = old_x_reg;
    old_y_next        = old_y_reg;
    paddle_pulse_next = 1'b0;
    wall_pulse_next   = 1'b0;
    game_over_next    = game_over_reg;
    wall_guard_next   = (wall_guard_reg != '0) ? wall_guard_reg - guard_w'(1) : '0;
    paddle_guard_next = (paddle_guard_reg != '0) ? paddle_guard_reg - guard_w'(1) : '0;
    x_dir_next        = x_dir_reg;
    left_scored_next  = left_scored_reg;
`ifdef SERVE_TOWARD_LOSER_EN
    after_point_next  = after_point_reg;
`endif
    case (state_reg)
      SERVE: begin
        old_x_next = centre_x;
        old_y_next = centre_y;
        if (serve_cnt_reg == serve_last) begin
          state_next     = PLAY;
          serve_cnt_next = '0;
`ifdef SERVE_TOWARD_LOSER_EN
          // Left scorer means right conceded, which needs x_dir = 1 (and vice versa).
          if (after_point_reg && (x_dir_reg != left_scored_reg)) begin
            paddle_pulse_next = 1'b1;
            paddle_guard_next = guard_load;
            x_dir_next        = ~x_dir_reg;
          end
`endif
        end else begin
          serve_cnt_next = serve_cnt_reg + cnt_w'(1);
        end
      end
      PLAY: begin
        old_x_next = bus.ball_x;
        old_y_next = bus.ball_y;
        if (!paddle_any && (goal_left || goal_right)) begin
          state_next       = POINT;
          left_scored_next = goal_left;
        end else begin
          if (wall_hit && (wall_guard_reg == '0)) begin
            wall_pulse_next = 1'b1;
            wall_guard_next = guard_load;
          end
          if (paddle_any && (paddle_guard_reg == '0)) begin
            paddle_pulse_next = 1'b1;
            paddle_guard_next = guard_load;
            x_dir_next        = ~x_dir_reg;
          end
        end
      end
      POINT: begin
        old_x_next = centre_x;
        old_y_next = centre_y;
`ifdef SERVE_TOWARD_LOSER_EN
        after_point_next = 1'b1;
`endif
        if (left_scored_reg) left_score_next = scorer_count;
        else                 right_score_next = scorer_count;
        if (scorer_count == win) begin
          state_next     = GAME_OVER;
          game_over_next = 1'b1;
        end else begin
          state_next = SERVE;
        end
      end
      default: begin
        wall_guard_next   = wall_guard_reg;
        paddle_guard_next = paddle_guard_reg;
      end
    endcase
  end

  assign bus.old_x           = old_x_reg;
  assign bus.old_y           = old_y_reg;
  assign bus.touching_paddle = paddle_pulse_reg;
  assign bus.touching_wall   = wall_pulse_reg;
  assign bus.left_score      = left_score_reg;
  assign bus.right_score     = right_score_reg;
  assign bus.state           = state_reg;
  assign bus.game_over       = game_over_reg;
endmodule

// File: doc/pong_referee.md
# pong_referee

Game-rules stage directly upstream/downstream of the ball stepper. Samples the stepped ball position every cycle, registers the position fed back to the stepper, and generates the `touching_paddle` / `touching_wall` bounce pulses that it consumes. Also detects goals, keeps both scores, and sequences serve / play / point / game-over.

## Interface
- `x_coords_width`, 10: ball/paddle x width
- `y_coords_width`, 10: ball/paddle y width
- `screen_w`, 640: playfield width (px)
- `screen_h`, 480: playfield height (px)
- `ball_size`, 8: ball edge length (px)
- `paddle_w`, 8: paddle width
- `paddle_h`, 64: paddle height
- `left_paddle_x`, 16: left paddle left edge
- `right_paddle_x`, 616: right paddle left edge
- `score_width`, 4: score counter width
- `win_score`, 11: score that ends the game
- `serve_delay`, 60: cycles held in SERVE
- `guard_cycles`, 3: retrigger suppression after a bounce pulse

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high
- `ball_x`  in  x_coords_width  stepped ball x (top-left corner)
- `ball_y`  in  y_coords_width  stepped ball y
- `left_paddle_y`  in  y_coords_width  left paddle top edge
- `right_paddle_y`  in  y_coords_width  right paddle top edge
- `old_x`  out  x_coords_width  registered x fed back to the stepper
- `old_y`  out  y_coords_width  registered y fed back to the stepper
- `touching_paddle`  out  1  one-cycle x-bounce pulse
- `touching_wall`  out  1  one-cycle y-bounce pulse
- `left_score`, `right_score`  out  score_width  scores
- `state`  out  2  SERVE=0, PLAY=1, POINT=2, GAME_OVER=3
- `game_over`  out  1  high in GAME_OVER

## Operation
- Reset values:
  - `old_x` = screen_w/2 − ball_size/2 (316); `old_y` = screen_h/2 − ball_size/2 (236).
  - Scores 0; `state` SERVE; pulses 0; `game_over` 0; serve counter 0; guard counters 0; `x_dir` 0.
- SERVE:
  - `old_x`/`old_y` are held at centre. Both pulses are 0.
  - The counter increments each cycle. When it reaches serve_delay−1, the FSM goes to PLAY and the counter clears.
- PLAY:
  - Each cycle `old_x`<=`ball_x` and `old_y`<=`ball_y`. Checks are evaluated on the sampled inputs.
  - Wall: `ball_y`==0, or `ball_y` >= screen_h−ball_size (this includes wrapped values) → `touching_wall`=1, unless the wall guard is nonzero.
  - Paddle, left: `ball_x` < left_paddle_x+paddle_w, `ball_x`+ball_size > left_paddle_x, and the y ranges overlap (`ball_y`+ball_size > paddle_y and `ball_y` < paddle_y+paddle_h).
  - Paddle, right: the same rules, applied to right_paddle_x.
  - A paddle hit gives `touching_paddle`=1, unless the paddle guard is nonzero.
  - Goal: `ball_x`==0 or `ball_x` >= screen_w (wrap from 0−1) → right scores. `ball_x` >= screen_w−ball_size and < screen_w → left scores.
  - Priority: paddle hit over goal in the same cycle. Wall and paddle pulses may coincide.
  - On a goal, go to POINT. No pulses are issued that cycle.
- Guards:
  - Each pulse loads its own guard counter with guard_cycles. The counter decrements to 0, and the pulse is suppressed while the counter is nonzero.
  - This covers the stepper's one extra step in the old direction.
- `x_dir` toggles on every emitted `touching_paddle`. It mirrors the stepper's x sign.
- POINT (one cycle):
  - The scorer's count increments.
  - If the new count equals win_score, go to GAME_OVER. Otherwise go to SERVE.
  - `old_x`/`old_y` reload centre.
- GAME_OVER:
  - Everything is frozen; `game_over`=1. Exit only by `reset`.
- Scores never exceed win_score. win_score must be < 2^score_width.

## Timing
- All outputs are registered. A pulse or position derived from the inputs at edge N is visible after edge N.
- Bounce pulses are exactly one cycle wide. Their minimum spacing on one axis is guard_cycles+1.
- Point latency: goal sampled at edge N → POINT after N. Score update and exit from POINT at N+1. SERVE (or GAME_OVER) starts after N+1.
- Serve length: exactly serve_delay cycles in SERVE.
- Reset has priority in any state, including mid-POINT. All registers take reset values at that edge.

## Configuration
- `SERVE_TOWARD_LOSER_EN`
  - Defined: on the last SERVE cycle after a point, emit one `touching_paddle` if `x_dir` does not point at the conceding side. Left concedes → `x_dir` must be 0; right concedes → `x_dir` must be 1.
  - Not defined: no pulse is emitted in SERVE, and the ball keeps its last direction.
  - The first serve after reset never pulses.

## Test plan
- Reset, then hold ball_x=316: state=0 for 60 cycles and old_x stays 316. In cycle 61, state=1.
- PLAY, ball_y=0 for 5 cycles: exactly one touching_wall pulse, no pulse in the next 3 cycles, then a second pulse on cycle 5.
- PLAY, ball_x=20, ball_y=100, left_paddle_y=80: touching_paddle=1 for one cycle. With left_paddle_y=200: no pulse.
- PLAY, ball_x=1023 (wrapped): right_score 0→1, state 2 for one cycle, then 0, and old_x=316.
- Preload left_score=10, then ball_x=635: left_score=11, state=3, game_over=1. Frozen until reset, which clears everything in one cycle.
- With `SERVE_TOWARD_LOSER_EN`, x_dir=0, and left scoring: one touching_paddle on the final SERVE cycle. Without the macro: none.
